// File: rtl/prog_ctr_pkg.sv
// Shared types and helpers for the multi-program fetch counter.
// The return-address stack is enabled by defining PROG_CTR_RAS_EN.
package prog_ctr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    RUN    = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam int DEF_PC_W        = 10;
  localparam int DEF_NUM_PROGS   = 4;
  localparam int DEF_PROG_STRIDE = 256;
  localparam int DEF_REL_W       = 6;
  localparam int DEF_RAS_DEPTH   = 4;

  // Program entry address, reduced modulo 2^width.
  function automatic int unsigned entry(input int unsigned sel,
                                        input int unsigned stride,
                                        input int unsigned width);
    int unsigned mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (sel * stride) & mask;
  endfunction

endpackage

// File: rtl/prog_ctr_multi_ras.sv
// Circular return-address stack; a push onto a full stack overwrites the oldest entry.
// Compiled only when PROG_CTR_RAS_EN is defined.
`ifdef PROG_CTR_RAS_EN
module ret_addr_stack
  import prog_ctr_pkg::*;
#(
  parameter int W     = DEF_PC_W,
  parameter int DEPTH = DEF_RAS_DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  input  logic         clear,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W:0]   r_cnt;
  logic [PTR_W-1:0] w_top_idx;

  assign w_top_idx = r_ptr - PTR_W'(1);
  assign top       = r_mem[w_top_idx];
  assign empty     = (r_cnt == '0);
  assign full      = (r_cnt == (PTR_W+1)'(DEPTH));

  // The pointer wraps, so the count saturates at DEPTH while old slots are reused.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (clear) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (push) begin
      r_ptr <= r_ptr + PTR_W'(1);
      if (!full) r_cnt <= r_cnt + (PTR_W+1)'(1);
    end else if (pop && !empty) begin
      r_ptr <= r_ptr - PTR_W'(1);
      r_cnt <= r_cnt - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) r_mem[r_ptr] <= push_data;
  end

endmodule
`endif

// File: rtl/prog_ctr_multi.sv
// Fetch-stage program counter with program select, branches, call/return and halt.
// Define PROG_CTR_RAS_EN to build the return-address stack and its sticky flags.
module prog_ctr_multi
  import prog_ctr_pkg::*;
#(
  parameter int PC_W        = DEF_PC_W,
  parameter int NUM_PROGS   = DEF_NUM_PROGS,
  parameter int PROG_STRIDE = DEF_PROG_STRIDE,
  parameter int REL_W       = DEF_REL_W,
  parameter int RAS_DEPTH   = DEF_RAS_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [$clog2(NUM_PROGS)-1:0] prog_sel,
  input  logic                         halt,
  input  logic                         branch_en,
  input  logic                         branch_rel,
  input  logic [PC_W-1:0]              target,
  input  logic [REL_W-1:0]             offset,
  input  logic                         call_en,
  input  logic                         ret_en,
  output logic [PC_W-1:0]              prog_ctr,
  output logic                         running,
  output logic                         ras_overflow,
  output logic                         ras_underflow
);

  state_t r_state, w_state_nxt;

  logic [PC_W-1:0]         r_pc, w_pc_nxt;
  logic [PC_W-1:0]         w_entry, w_pc_inc, w_pc_rel, w_ret_pc;
  logic signed [REL_W-1:0] w_off_s;
  logic signed [PC_W-1:0]  w_off_ext;
  logic                    w_active, w_do_call, w_do_ret;

  assign w_entry   = PC_W'(entry(32'(prog_sel), PROG_STRIDE, PC_W));
  assign w_pc_inc  = r_pc + PC_W'(1);
  assign w_off_s   = offset;
  assign w_off_ext = PC_W'(w_off_s);
  assign w_pc_rel  = r_pc + w_off_ext;
  assign prog_ctr  = r_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = ARMED;
      ARMED:   if (!start) w_state_nxt = RUN;
      RUN:     if (start) w_state_nxt = ARMED;
               else if (halt) w_state_nxt = HALTED;
      HALTED:  if (start) w_state_nxt = ARMED;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Stack/flow decodes only fire in RUN once start and halt have been ruled out.
  always_comb begin
    running   = (r_state == RUN);
    w_active  = running && !start && !halt;
    w_do_ret  = w_active && ret_en;
    w_do_call = w_active && call_en && !ret_en;
  end

  always_comb begin
    w_pc_nxt = r_pc;
    if (start) begin
      w_pc_nxt = w_entry;
    end else if (w_active) begin
      if (ret_en)         w_pc_nxt = w_ret_pc;
      else if (call_en)   w_pc_nxt = target;
      else if (branch_en) w_pc_nxt = branch_rel ? w_pc_rel : target;
      else                w_pc_nxt = w_pc_inc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_pc <= '0;
    else       r_pc <= w_pc_nxt;
  end

`ifdef PROG_CTR_RAS_EN
  logic            w_empty, w_full;
  logic [PC_W-1:0] w_top;

  ret_addr_stack #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (w_do_call),
    .pop       (w_do_ret && !w_empty),
    .push_data (w_pc_inc),
    .clear     (start),
    .top       (w_top),
    .empty     (w_empty),
    .full      (w_full)
  );

  assign w_ret_pc = w_empty ? w_pc_inc : w_top;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else if (start) begin
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      if (w_do_call && w_full)  ras_overflow  <= 1'b1;
      if (w_do_ret  && w_empty) ras_underflow <= 1'b1;
    end
  end
`else
  assign w_ret_pc      = w_pc_inc;
  assign ras_overflow  = 1'b0;
  assign ras_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_prog_ctr_multi.sv
// Self-checking bench for prog_ctr_multi: directed test-plan steps plus random traffic
// checked against a queue-based behavioural model.
module tb_prog_ctr_multi;

  localparam int MOD    = 1024;
  localparam int STRIDE = 256;
  localparam int DEPTH  = 4;
`ifdef PROG_CTR_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0, halt = 1'b0, branch_en = 1'b0, branch_rel = 1'b0;
  logic       call_en = 1'b0, ret_en = 1'b0;
  logic [1:0] prog_sel = '0;
  logic [9:0] target = '0;
  logic [5:0] offset = '0;
  logic [9:0] prog_ctr;
  logic       running, ras_overflow, ras_underflow;

  always #5 clk = ~clk;

  prog_ctr_multi #(
    .PC_W(10), .NUM_PROGS(4), .PROG_STRIDE(STRIDE), .REL_W(6), .RAS_DEPTH(DEPTH)
  ) u_dut (
    .clk(clk), .reset(reset), .start(start), .prog_sel(prog_sel), .halt(halt),
    .branch_en(branch_en), .branch_rel(branch_rel), .target(target), .offset(offset),
    .call_en(call_en), .ret_en(ret_en), .prog_ctr(prog_ctr), .running(running),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: mode 0 idle, 1 armed, 2 run, 3 halted.
  int m_mode = 0;
  int m_pc   = 0;
  int m_stack[$];
  bit m_ovf  = 1'b0;
  bit m_unf  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pc"},  32'(prog_ctr),      32'(m_pc));
    chk({tag, ".run"}, 32'(running),       32'(m_mode == 2));
    chk({tag, ".ovf"}, 32'(ras_overflow),  32'(m_ovf));
    chk({tag, ".unf"}, 32'(ras_underflow), 32'(m_unf));
  endtask

  task automatic model_step();
    int o;
    o = int'(offset);
    if (o >= 32) o -= 64;
    if (start) begin
      m_mode = 1;
      m_pc   = (int'(prog_sel) * STRIDE) % MOD;
      m_stack.delete();
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else if (m_mode == 1) begin
      m_mode = 2;
    end else if (m_mode == 2) begin
      if (halt) begin
        m_mode = 3;
      end else if (ret_en) begin
        if (RAS_EN && m_stack.size() > 0) begin
          m_pc = m_stack.pop_back();
        end else begin
          m_pc = (m_pc + 1) % MOD;
          if (RAS_EN) m_unf = 1'b1;
        end
      end else if (call_en) begin
        if (RAS_EN) begin
          if (m_stack.size() == DEPTH) begin
            void'(m_stack.pop_front());
            m_ovf = 1'b1;
          end
          m_stack.push_back((m_pc + 1) % MOD);
        end
        m_pc = int'(target);
      end else if (branch_en) begin
        m_pc = branch_rel ? (((m_pc + o) % MOD) + MOD) % MOD : int'(target);
      end else begin
        m_pc = (m_pc + 1) % MOD;
      end
    end
  endtask

  task automatic step(input logic s, input logic [1:0] sel, input logic h, input logic c,
                      input logic r, input logic b, input logic rel,
                      input logic [9:0] tgt, input logic [5:0] off, input string tag);
    start = s; prog_sel = sel; halt = h; call_en = c; ret_en = r;
    branch_en = b; branch_rel = rel; target = tgt; offset = off;
    model_step();
    @(posedge clk); #1;
    chk_all(tag);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #2;
    m_mode = 0; m_pc = 0; m_stack.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    chk_all(tag);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #1;
    do_reset("rst");

    step(1, 2, 0, 0, 0, 0, 0, 0, 0, "arm1");
    step(1, 2, 0, 0, 0, 0, 0, 0, 0, "arm2");
    chk("arm_pc", 32'(prog_ctr), 32'd512);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "run0");
    chk("run0_pc", 32'(prog_ctr), 32'd512);
    chk("run0_running", 32'(running), 32'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "run1");
    chk("run1_pc", 32'(prog_ctr), 32'd513);

    step(0, 0, 0, 0, 0, 1, 0, 10'd20,   0, "br20");
    step(0, 0, 0, 0, 0, 1, 0, 10'd100,  0, "br100");
    chk("br_abs", 32'(prog_ctr), 32'd100);
    step(0, 0, 0, 0, 0, 1, 1, 0, 6'b111100, "rel_m4");
    chk("br_rel_neg", 32'(prog_ctr), 32'd96);
    step(0, 0, 0, 0, 0, 1, 0, 10'd1020, 0, "br1020");
    step(0, 0, 0, 0, 0, 1, 1, 0, 6'd7, "rel_p7");
    chk("br_rel_wrap", 32'(prog_ctr), 32'd3);

    step(0, 0, 0, 0, 0, 1, 0, 10'd10, 0, "br10");
    step(0, 0, 0, 1, 0, 0, 0, 10'd40, 0, "call40");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "inc41");
    step(0, 0, 0, 1, 0, 0, 0, 10'd80, 0, "call80");
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, "ret1");
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, "ret2");
    chk("nest_pc", 32'(prog_ctr), RAS_EN ? 32'd11 : 32'd82);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, "ret_empty");
    chk("underflow", 32'(ras_underflow), 32'(RAS_EN));

    step(1, 0, 0, 0, 0, 0, 0, 0, 0, "restart0");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "run_p0");
    for (int i = 1; i <= 5; i++)
      step(0, 0, 0, 1, 0, 0, 0, 10'(i * 100), 0, $sformatf("ovcall%0d", i));
    chk("overflow", 32'(ras_overflow), 32'(RAS_EN));
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 1, 0, 0, 0, 0, $sformatf("ovret%0d", i));
      chk($sformatf("ovret%0d_lifo", i), 32'(prog_ctr), RAS_EN ? 32'(401 - 100 * i) : 32'(501 + i));
    end
    step(1, 3, 0, 0, 0, 0, 0, 0, 0, "restart3");
    chk("ovf_cleared", 32'(ras_overflow), 32'd0);

    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "run_p3");
    step(0, 0, 0, 0, 0, 1, 0, 10'd30, 0, "br30");
    step(0, 0, 1, 1, 0, 0, 0, 10'd200, 0, "halt_call");
    chk("halt_pc", 32'(prog_ctr), 32'd30);
    step(0, 0, 0, 0, 0, 1, 0, 10'd5, 0, "halt_br");
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, "halt_ret");
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, "halt_start");
    chk("rearm_pc", 32'(prog_ctr), 32'd256);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, "run_p1");
    step(0, 0, 0, 0, 0, 1, 0, 10'd77, 0, "br77");
    #2;
    do_reset("midrun_rst");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "idle_after_rst");

    step(1, 2'($urandom), 0, 0, 0, 0, 0, 0, 0, "rnd_arm");
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 40) == 0, 2'($urandom), ($urandom % 30) == 0,
           ($urandom % 6) == 0, ($urandom % 6) == 0, ($urandom % 4) == 0,
           1'($urandom), 10'($urandom), 6'($urandom), $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prog_ctr_multi.md
Name: prog_ctr_multi

Overview:
Parametrised successor to the instruction-fetch program counter. Adds:
- Selectable program entry points.
- Absolute and PC-relative branches.
- Call/return through a small return-address stack.
- A halt state.
Sits in the fetch stage and drives the instruction memory address. Branch/call/return controls come from the decode/ALU stage.

Parameters:
PC_W, 10, program counter width in bits
NUM_PROGS, 4, number of selectable programs
PROG_STRIDE, 256, address spacing of program entry points (entry = prog_sel*PROG_STRIDE, truncated to PC_W)
REL_W, 6, width of signed relative branch offset
RAS_DEPTH, 4, return-address stack entries (power of two, >=2)

Ports:
clk  in  1  clock, rising-edge
reset  in  1  asynchronous, active-high reset
start  in  1  arm/restart request; PC held at entry point while high
prog_sel  in  $clog2(NUM_PROGS)  program to launch, sampled while start high
halt  in  1  stop fetching; PC frozen
branch_en  in  1  take branch this cycle
branch_rel  in  1  1 = relative (PC+offset), 0 = absolute (target)
target  in  PC_W  absolute branch/call target
offset  in  REL_W  signed two's-complement relative offset
call_en  in  1  call: push PC+1, jump to target
ret_en  in  1  return: pop stack into PC
prog_ctr  out  PC_W  current instruction address
running  out  1  high in RUN state
ras_overflow  out  1  sticky: push onto full stack
ras_underflow  out  1  sticky: pop from empty stack

Behaviour:
- Reset (asynchronous, active-high): state IDLE, prog_ctr=0, running=0, stack empty, both flags 0. Reset mid-run aborts immediately.
- All other updates occur on the rising edge of clk. prog_ctr is registered, so the new value is visible after the edge.
- States:
  - IDLE: start=1 -> ARMED, prog_ctr<=entry(prog_sel), flags cleared, stack emptied. Otherwise hold.
  - ARMED: start=1 -> stay; prog_ctr re-latched from prog_sel each edge. start=0 -> RUN, prog_ctr held (the first RUN cycle fetches the entry address).
  - RUN: running=1. Priority per edge: start > halt > ret_en > call_en > branch_en > increment.
    - start: -> ARMED, entry latched, flags/stack cleared.
    - halt: -> HALTED, prog_ctr held.
    - ret_en, stack non-empty: prog_ctr<=top, pop.
    - ret_en, stack empty: prog_ctr<=prog_ctr+1, ras_underflow<=1.
    - call_en: push prog_ctr+1, prog_ctr<=target. If the stack is full, the oldest entry is overwritten (circular) and ras_overflow<=1. Depth stays RAS_DEPTH.
    - branch_en, branch_rel=0: prog_ctr<=target.
    - branch_en, branch_rel=1: prog_ctr<=prog_ctr+sign_extend(offset).
    - otherwise: prog_ctr<=prog_ctr+1.
  - HALTED: running=0, prog_ctr held, all branch/call/ret inputs ignored. start=1 -> ARMED.
- Arithmetic:
  - All PC arithmetic is modulo 2^PC_W. Max+1 wraps to 0; a negative relative offset below 0 wraps high.
  - offset is sign-extended to PC_W before the add.
- Simultaneous events: halt with ret_en/call_en means no stack change. ret_en with call_en means ret wins and nothing is pushed.

Optional Feature:
Macro PROG_CTR_RAS_EN.
- Defined: return-address stack, call/ret and flags behave as above.
- Undefined: no stack storage. call_en acts as an absolute jump to target with no push. ret_en is treated as increment. ras_overflow and ras_underflow are tied to 0.

Decomposition:
- Package prog_ctr_pkg holds:
  - state enum (IDLE, ARMED, RUN, HALTED)
  - default parameter constants
  - an entry-address function entry(sel, stride, width)
- Sub-module ret_addr_stack (compiled only under PROG_CTR_RAS_EN):
  - Circular LIFO parameterised by width and depth.
  - Inputs: push, pop, push_data, clear.
  - Outputs: top, empty, full.

Test Plan:
1. Reset and launch: reset=1 -> prog_ctr=0, running=0. start=1 with prog_sel=2 for 2 edges -> prog_ctr=512. start=0 -> first edge 512, running=1; next edge 513.
2. Branching: at pc=20, absolute branch target=100 -> 100. Relative offset=-4 (6'b111100) -> 96. Relative at pc=1020 with offset=+7 (PC_W=10) -> 3 (wrap).
3. Nested calls: calls at pc=10 (target 40) and 41 (target 80), then two rets -> pc 80, 42, 11. Flags stay 0. A further ret -> pc+1 and ras_underflow=1.
4. Overflow: 5 calls with RAS_DEPTH=4 -> ras_overflow=1; 4 rets return the 4 newest addresses in LIFO order. A restart via start clears the flag.
5. Halt and priority: halt with call_en at pc=30 -> HALTED, pc=30, no push. Later branch_en ignored. start=1 -> ARMED at entry(prog_sel).
6. Mid-run reset: assert reset asynchronously between edges at pc=77 -> prog_ctr=0 immediately, state IDLE. Build without PROG_CTR_RAS_EN -> call jumps to target, ret increments, flags stay 0.
